// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. Latches BCD digits and decimal points once per
// frame, scans digit 0..3 with a blanking gap at the start of each slot.
// All outputs are registered and active-low (except frame_start).
// Optional feature: define SEG_LZB_EN for leading-zero blanking.
module seg_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits,
    input  logic [3:0]  dp,
    output logic [6:0]  seg,
    output logic        dp_out,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   fdig;
    logic [3:0]    fdp;

    logic [0:0]    state;
    logic [3:0]    nib;
    logic [6:0]    seg_dec;
    logic          lz_hide;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic [3:0]    an_nxt;
    logic          frame_edge;

    // Slot phase: blank during the first BLANK_CYCLES of every slot
    always_comb begin
        state      = (cnt < BLANK_END) ? ST_BLANK : ST_DRIVE;
        frame_edge = (cnt == '0) && (idx == 2'd0);
        nib        = fdig[{idx, 2'b00} +: 4];
    end

    // BCD to active-low gfedcba; non-BCD nibbles render as all-off
    always_comb begin
        case (nib)
            4'd0:    seg_dec = 7'b1000000;
            4'd1:    seg_dec = 7'b1111001;
            4'd2:    seg_dec = 7'b0100100;
            4'd3:    seg_dec = 7'b0110000;
            4'd4:    seg_dec = 7'b0011001;
            4'd5:    seg_dec = 7'b0010010;
            4'd6:    seg_dec = 7'b0000010;
            4'd7:    seg_dec = 7'b1111000;
            4'd8:    seg_dec = 7'b0000000;
            4'd9:    seg_dec = 7'b0010000;
            default: seg_dec = 7'b1111111;
        endcase
    end

    // Leading-zero suppression: digit i hides when it and all higher digits are zero
    always_comb begin
        lz_hide = 1'b0;
`ifdef SEG_LZB_EN
        case (idx)
            2'd3:    lz_hide = (fdig[15:12] == 4'h0);
            2'd2:    lz_hide = (fdig[15:8]  == 8'h00);
            2'd1:    lz_hide = (fdig[15:4]  == 12'h000);
            default: lz_hide = 1'b0;
        endcase
`endif
    end

    // Next output pattern from the current slot state
    always_comb begin
        an_nxt  = '1;
        seg_nxt = '1;
        dp_nxt  = 1'b1;
        if (state == ST_DRIVE && !lz_hide) begin
            an_nxt  = ~(4'b0001 << idx);
            seg_nxt = seg_dec;
            dp_nxt  = ~fdp[idx];
        end
    end

    // Slot counter, digit index and per-frame input latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            idx  <= 2'd0;
            fdig <= '0;
            fdp  <= '0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (frame_edge) begin
                fdig <= digits;
                fdp  <= dp;
            end
        end
    end

    // Registered outputs; reset forces the display dark immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= '1;
            seg         <= '1;
            dp_out      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_nxt;
            seg         <= seg_nxt;
            dp_out      <= dp_nxt;
            frame_start <= frame_edge;
        end
    end

endmodule
